// File: rtl/rf_port_arbiter_pkg.sv
// Shared types for the two-port register file arbiter: FSM states, the latched
// request record and the default data/address widths.
package rf_arb_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr1;
        logic [AW-1:0] addr2;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rf_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational. i_prio selects which
// requester wins a tie (0 = req[0], 1 = req[1]); the pointer lives in the caller.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (!i_prio) begin
            if (i_req[0])      o_grant = 2'b01;
            else if (i_req[1]) o_grant = 2'b10;
        end else begin
            if (i_req[1])      o_grant = 2'b10;
            else if (i_req[0]) o_grant = 2'b01;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one 32x32 register file between requesters A and B, one transaction in
// flight. Optional feature: define RFA_ZERO_REG_EN to hardwire register 0 to zero.
//
// state   | meaning
// IDLE    | waiting for a request; grants one combinationally and latches it
// ISSUE   | drives the register file strobe for exactly one cycle
// CAPTURE | registers read data (or zero for a write acknowledgement)
// RESP    | presents the response to the owner until it is consumed
module rf_port_arbiter
    import rf_arb_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_a_req_valid,
    output logic          o_a_req_ready,
    input  logic          i_a_req_write,
    input  logic [AW-1:0] i_a_req_addr1,
    input  logic [AW-1:0] i_a_req_addr2,
    input  logic [AW-1:0] i_a_req_waddr,
    input  logic [DW-1:0] i_a_req_wdata,
    output logic          o_a_rsp_valid,
    input  logic          i_a_rsp_ready,

    input  logic          i_b_req_valid,
    output logic          o_b_req_ready,
    input  logic          i_b_req_write,
    input  logic [AW-1:0] i_b_req_addr1,
    input  logic [AW-1:0] i_b_req_addr2,
    input  logic [AW-1:0] i_b_req_waddr,
    input  logic [DW-1:0] i_b_req_wdata,
    output logic          o_b_rsp_valid,
    input  logic          i_b_rsp_ready,

    output logic [DW-1:0] o_rsp_rd1,
    output logic [DW-1:0] o_rsp_rd2,

    output logic          o_rf_read,
    output logic          o_rf_write,
    output logic [AW-1:0] o_rf_o1_addr,
    output logic [AW-1:0] o_rf_o2_addr,
    output logic [AW-1:0] o_rf_in_addr,
    output logic [DW-1:0] o_rf_in,
    input  logic [DW-1:0] i_rf_o1,
    input  logic [DW-1:0] i_rf_o2
);

`ifdef RFA_ZERO_REG_EN
    localparam logic ZERO_REG = 1'b1;
`else
    localparam logic ZERO_REG = 1'b0;
`endif

    state_t        r_state;
    state_t        w_next;
    logic          r_prio;
    logic          r_owner;
    req_t          r_req;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;

    logic [1:0]    w_grant;
    logic          w_accept;
    logic          w_rsp_hs;
    logic          w_owner_ready;
    req_t          w_sel_req;
    logic          w_wr_masked;
    logic          w_rd1_masked;
    logic          w_rd2_masked;

    rr_arb2 u_arb (
        .i_req   ({i_b_req_valid, i_a_req_valid}),
        .i_prio  (r_prio),
        .o_grant (w_grant)
    );

    assign w_accept      = (r_state == IDLE) && (w_grant != 2'b00);
    assign w_owner_ready = r_owner ? i_b_rsp_ready : i_a_rsp_ready;
    assign w_rsp_hs      = (r_state == RESP) && w_owner_ready;

    // Register 0 handling only matters when the zero-register build option is on.
    assign w_wr_masked  = ZERO_REG && (r_req.waddr == '0);
    assign w_rd1_masked = ZERO_REG && (r_req.addr1 == '0);
    assign w_rd2_masked = ZERO_REG && (r_req.addr2 == '0);

    always_comb begin
        w_sel_req = '0;
        if (w_grant[1]) begin
            w_sel_req.write = i_b_req_write;
            w_sel_req.addr1 = i_b_req_addr1;
            w_sel_req.addr2 = i_b_req_addr2;
            w_sel_req.waddr = i_b_req_waddr;
            w_sel_req.wdata = i_b_req_wdata;
        end else begin
            w_sel_req.write = i_a_req_write;
            w_sel_req.addr1 = i_a_req_addr1;
            w_sel_req.addr2 = i_a_req_addr2;
            w_sel_req.waddr = i_a_req_waddr;
            w_sel_req.wdata = i_a_req_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP:    if (w_rsp_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_a_req_ready = 1'b0;
        o_b_req_ready = 1'b0;
        o_a_rsp_valid = 1'b0;
        o_b_rsp_valid = 1'b0;
        o_rf_read     = 1'b0;
        o_rf_write    = 1'b0;
        case (r_state)
            IDLE: begin
                o_a_req_ready = w_grant[0];
                o_b_req_ready = w_grant[1];
            end
            ISSUE: begin
                o_rf_read  = !r_req.write;
                o_rf_write = r_req.write && !w_wr_masked;
            end
            RESP: begin
                o_a_rsp_valid = !r_owner;
                o_b_rsp_valid = r_owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_req   <= '0;
            r_rd1   <= '0;
            r_rd2   <= '0;
        end else begin
            if (w_accept) begin
                r_req   <= w_sel_req;
                r_owner <= w_grant[1];
            end
            if (r_state == CAPTURE) begin
                if (r_req.write) begin
                    r_rd1 <= '0;
                    r_rd2 <= '0;
                end else begin
                    r_rd1 <= w_rd1_masked ? '0 : i_rf_o1;
                    r_rd2 <= w_rd2_masked ? '0 : i_rf_o2;
                end
            end
            if (w_rsp_hs) r_prio <= !r_owner;
        end
    end

    // Addresses and write data come straight from the latched request, so they
    // hold their last values between transactions.
    assign o_rf_o1_addr = r_req.addr1;
    assign o_rf_o2_addr = r_req.addr2;
    assign o_rf_in_addr = r_req.waddr;
    assign o_rf_in      = r_req.wdata;
    assign o_rsp_rd1    = r_rd1;
    assign o_rsp_rd2    = r_rd2;

endmodule
